// File: rtl/eastwest_forwarder_if.sv
// Bundle of the upstream-buffer read port and the three downstream write ports
// seen by the east/west forwarder.
interface eastwest_forwarder_if #(
    parameter int PACKET_WIDTH = 30,
    parameter int DX_WIDTH     = 9
);
    logic [PACKET_WIDTH-1:0]          in_dout;
    logic                             in_empty;
    logic                             in_read_en;

    logic                             east_full;
    logic                             west_full;
    logic                             local_full;

    logic [PACKET_WIDTH-1:0]          east_din;
    logic [PACKET_WIDTH-1:0]          west_din;
    logic [PACKET_WIDTH-DX_WIDTH-1:0] local_din;

    logic                             east_valid;
    logic                             west_valid;
    logic                             local_valid;

    // The forwarder pops the input buffer and pushes the output buffers.
    modport master (
        input  in_dout, in_empty, east_full, west_full, local_full,
        output in_read_en, east_din, west_din, local_din,
               east_valid, west_valid, local_valid
    );

    modport slave (
        output in_dout, in_empty, east_full, west_full, local_full,
        input  in_read_en, east_din, west_din, local_din,
               east_valid, west_valid, local_valid
    );
endinterface

// File: rtl/eastwest_forwarder.sv
// Single-stage horizontal forwarder: pops a spike packet, routes it east/west by
// the sign of dx (moving dx one hop toward zero) or to local with dx stripped.
module eastwest_forwarder #(
    parameter int PACKET_WIDTH = 30,
    parameter int DX_WIDTH     = 9
) (
    input  logic                clk,
    input  logic                rst,
    eastwest_forwarder_if.master bus,
    output logic [1:0]          state_dbg
);
    localparam int PAYLOAD_WIDTH = PACKET_WIDTH - DX_WIDTH;
    localparam logic [DX_WIDTH-1:0] DX_ONE = DX_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ROUTE = 2'd2
    } state_t;

    state_t                   state_q;
    state_t                   state_d;
    logic [PACKET_WIDTH-1:0]  pkt_q;

    logic [DX_WIDTH-1:0]      dx;
    logic [PAYLOAD_WIDTH-1:0] payload;
    logic                     to_east;
    logic                     to_west;
    logic                     to_local;
    logic                     target_full;

    logic                     read_en_d;
    logic                     east_v_d;
    logic                     west_v_d;
    logic                     local_v_d;

    assign dx      = pkt_q[PACKET_WIDTH-1 -: DX_WIDTH];
    assign payload = pkt_q[PAYLOAD_WIDTH-1:0];

    assign to_local = (dx == '0);
    assign to_west  = dx[DX_WIDTH-1];
    assign to_east  = !to_local && !to_west;

    // Only the full flag of the decoded target can stall the packet.
    always_comb begin
        target_full = bus.local_full;
        if (to_east) begin
            target_full = bus.east_full;
        end else if (to_west) begin
            target_full = bus.west_full;
        end
    end

    // Handshake: in_read_en pops only when in_empty is low, data arrives one
    // cycle later; each *_valid is a one-cycle write strobe, issued only when
    // that output's full flag is low, and the write happens on that clock edge.
    always_comb begin
        state_d   = state_q;
        read_en_d = 1'b0;
        east_v_d  = 1'b0;
        west_v_d  = 1'b0;
        local_v_d = 1'b0;
        case (state_q)
            IDLE: begin
                read_en_d = !bus.in_empty;
                if (!bus.in_empty) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = ROUTE;
            end
            ROUTE: begin
                if (!target_full) begin
                    east_v_d  = to_east;
                    west_v_d  = to_west;
                    local_v_d = to_local;
                    if (!bus.in_empty) begin
                        read_en_d = 1'b1;
                        state_d   = FETCH;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pkt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == FETCH) begin
                pkt_q <= bus.in_dout;
            end
        end
    end

    // IDLE would otherwise pop a non-empty buffer while reset is still held.
    assign bus.in_read_en  = read_en_d && !rst;
    assign bus.east_valid  = east_v_d;
    assign bus.west_valid  = west_v_d;
    assign bus.local_valid = local_v_d;

    // dx wraps modulo 2^DX_WIDTH; dx==0 never reaches these two buses.
    assign bus.east_din  = {dx - DX_ONE, payload};
    assign bus.west_din  = {dx + DX_ONE, payload};
    assign bus.local_din = payload;

    assign state_dbg = state_q;

    a_one_valid: assert property (@(posedge clk) disable iff (rst)
        $onehot0({bus.east_valid, bus.west_valid, bus.local_valid}));

    a_no_pop_empty: assert property (@(posedge clk) disable iff (rst)
        !(bus.in_read_en && bus.in_empty));

    a_valid_in_route: assert property (@(posedge clk) disable iff (rst)
        (bus.east_valid || bus.west_valid || bus.local_valid) |-> (state_q == ROUTE));
endmodule

// File: tb/tb_eastwest_forwarder.sv
// Directed and randomized bench for eastwest_forwarder with an upstream buffer
// model and per-destination expected queues.
module tb_eastwest_forwarder;
    localparam int PACKET_WIDTH = 30;
    localparam int DX_WIDTH     = 9;
    localparam int PL_WIDTH     = PACKET_WIDTH - DX_WIDTH;

    localparam int D_EAST  = 0;
    localparam int D_WEST  = 1;
    localparam int D_LOCAL = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] state_dbg;
    logic       hold_empty = 1'b1;

    int checks     = 0;
    int errors     = 0;
    int pop_count  = 0;
    int push_count = 0;
    int strobes    = 0;
    int discarded  = 0;

    logic [PACKET_WIDTH-1:0] src_q[$];
    logic [PACKET_WIDTH-1:0] east_q[$];
    logic [PACKET_WIDTH-1:0] west_q[$];
    logic [PL_WIDTH-1:0]     local_q[$];

    eastwest_forwarder_if #(.PACKET_WIDTH(PACKET_WIDTH), .DX_WIDTH(DX_WIDTH)) bus ();

    eastwest_forwarder #(.PACKET_WIDTH(PACKET_WIDTH), .DX_WIDTH(DX_WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- check helper ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- upstream buffer model ----------------
    always @(posedge clk) begin
        if (!rst && bus.in_read_en && !bus.in_empty && src_q.size() > 0) begin
            bus.in_dout <= src_q.pop_front();
            pop_count++;
        end
    end

    always @(negedge clk) begin
        #1;
        bus.in_empty = hold_empty || (src_q.size() == 0);
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [PACKET_WIDTH-1:0] e;
        logic [PL_WIDTH-1:0]     l;
        #3;
        if (!rst) begin
            chk("one_hot_valid",
                32'($countones({bus.east_valid, bus.west_valid, bus.local_valid}) <= 1), 32'd1);
            chk("pop_while_empty", 32'(bus.in_read_en && bus.in_empty), 32'd0);
            if (bus.east_valid) begin
                strobes++;
                chk("east_expected", 32'(east_q.size() > 0), 32'd1);
                if (east_q.size() > 0) begin
                    e = east_q.pop_front();
                    chk("east_din", 32'(bus.east_din), 32'(e));
                end
            end
            if (bus.west_valid) begin
                strobes++;
                chk("west_expected", 32'(west_q.size() > 0), 32'd1);
                if (west_q.size() > 0) begin
                    e = west_q.pop_front();
                    chk("west_din", 32'(bus.west_din), 32'(e));
                end
            end
            if (bus.local_valid) begin
                strobes++;
                chk("local_expected", 32'(local_q.size() > 0), 32'd1);
                if (local_q.size() > 0) begin
                    l = local_q.pop_front();
                    chk("local_din", 32'(bus.local_din), 32'(l));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_pkt(input logic [PACKET_WIDTH-1:0] pkt, input int dest,
                            input logic [PACKET_WIDTH-1:0] exp);
        src_q.push_back(pkt);
        push_count++;
        case (dest)
            D_EAST:  east_q.push_back(exp);
            D_WEST:  west_q.push_back(exp);
            default: local_q.push_back(exp[PL_WIDTH-1:0]);
        endcase
    endtask

    task automatic step();
        @(negedge clk);
        #3;
    endtask

    function automatic logic [2:0] valids();
        return {bus.east_valid, bus.west_valid, bus.local_valid};
    endfunction

    // One isolated packet: pop at t, capture at t+1, strobe at t+2, idle at t+3.
    task automatic send_single(input string tag, input logic [PACKET_WIDTH-1:0] pkt,
                               input int dest, input logic [PACKET_WIDTH-1:0] exp,
                               input logic [2:0] exp_v);
        @(negedge clk);
        push_pkt(pkt, dest, exp);
        hold_empty = 1'b0;
        #3;
        chk({tag, "_read_en_t0"}, 32'(bus.in_read_en), 32'd1);
        chk({tag, "_state_t0"}, 32'(state_dbg), 32'd0);
        step();
        chk({tag, "_read_en_t1"}, 32'(bus.in_read_en), 32'd0);
        chk({tag, "_valids_t1"}, 32'(valids()), 32'd0);
        chk({tag, "_state_t1"}, 32'(state_dbg), 32'd1);
        step();
        chk({tag, "_valids_t2"}, 32'(valids()), 32'(exp_v));
        chk({tag, "_state_t2"}, 32'(state_dbg), 32'd2);
        step();
        chk({tag, "_valids_t3"}, 32'(valids()), 32'd0);
        chk({tag, "_state_t3"}, 32'(state_dbg), 32'd0);
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        logic [DX_WIDTH-1:0]     dx_tab[6];
        logic [DX_WIDTH-1:0]     dx_exp[6];
        int                      dst_tab[6];
        logic [DX_WIDTH-1:0]     rdx;
        logic [PL_WIDTH-1:0]     rpl;
        int                      p0;
        bit                      done;

        bus.east_full  = 1'b0;
        bus.west_full  = 1'b0;
        bus.local_full = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        #3;
        chk("rst_read_en", 32'(bus.in_read_en), 32'd0);
        chk("rst_valids", 32'(valids()), 32'd0);
        chk("rst_state", 32'(state_dbg), 32'd0);
        chk("rst_local_din", 32'(bus.local_din), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single packets, payload 0x1234
        send_single("dx_p3", {9'h003, 21'h01234}, D_EAST,  {9'h002, 21'h01234}, 3'b100);
        send_single("dx_m2", {9'h1FE, 21'h01234}, D_WEST,  {9'h1FF, 21'h01234}, 3'b010);
        send_single("dx_0",  {9'h000, 21'h01234}, D_LOCAL, {9'h000, 21'h01234}, 3'b001);

        // dx boundaries
        send_single("dx_min", {9'h100, 21'h0ABCD}, D_WEST, {9'h101, 21'h0ABCD}, 3'b010);
        send_single("dx_max", {9'h0FF, 21'h0ABCD}, D_EAST, {9'h0FE, 21'h0ABCD}, 3'b100);
        send_single("dx_p1",  {9'h001, 21'h00077}, D_EAST, {9'h000, 21'h00077}, 3'b100);
        send_single("dx_m1",  {9'h1FF, 21'h00077}, D_WEST, {9'h000, 21'h00077}, 3'b010);

        // Back-to-back stream of 8, cycling east/west/local
        dx_tab  = '{9'h005, 9'h1FB, 9'h000, 9'h040, 9'h1C0, 9'h000};
        dx_exp  = '{9'h004, 9'h1FC, 9'h000, 9'h03F, 9'h1C1, 9'h000};
        dst_tab = '{D_EAST, D_WEST, D_LOCAL, D_EAST, D_WEST, D_LOCAL};
        @(negedge clk);
        p0 = pop_count;
        for (int i = 0; i < 8; i++) begin
            push_pkt({dx_tab[i % 6], 21'(32'h100 + i)}, dst_tab[i % 6],
                     {dx_exp[i % 6], 21'(32'h100 + i)});
        end
        hold_empty = 1'b0;
        #3;
        chk("stream_first_pop", 32'(bus.in_read_en), 32'd1);
        for (int i = 1; i <= 17; i++) begin
            step();
            chk("stream_strobe", 32'(valids() != 3'b000), 32'((i % 2 == 0) && (i <= 16)));
        end
        chk("stream_pops", 32'(pop_count - p0), 32'd8);
        chk("stream_drained", 32'(east_q.size() + west_q.size() + local_q.size()), 32'd0);

        // Backpressure on east, west/local full toggling meanwhile
        @(negedge clk);
        bus.east_full = 1'b1;
        push_pkt({9'h001, 21'h0BEEF}, D_EAST, {9'h000, 21'h0BEEF});
        push_pkt({9'h1FD, 21'h0CAFE}, D_WEST, {9'h1FE, 21'h0CAFE});
        #3;
        chk("bp_first_pop", 32'(bus.in_read_en), 32'd1);
        step();
        step();
        chk("bp_in_route", 32'(state_dbg), 32'd2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.west_full  = ~bus.west_full;
            bus.local_full = ~bus.local_full;
            #3;
            chk("bp_stall_valids", 32'(valids()), 32'd0);
            chk("bp_stall_read_en", 32'(bus.in_read_en), 32'd0);
        end
        @(negedge clk);
        bus.east_full  = 1'b0;
        bus.west_full  = 1'b0;
        bus.local_full = 1'b0;
        #3;
        chk("bp_release_valids", 32'(valids()), 32'b100);
        chk("bp_release_read_en", 32'(bus.in_read_en), 32'd1);
        step();
        step();
        chk("bp_second_valids", 32'(valids()), 32'b010);
        step();

        // Asynchronous reset while a packet is stalled in ROUTE
        @(negedge clk);
        bus.west_full = 1'b1;
        push_pkt({9'h1F0, 21'h00555}, D_WEST, {9'h1F1, 21'h00555});
        #3;
        step();
        step();
        chk("arst_pre_state", 32'(state_dbg), 32'd2);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_valids", 32'(valids()), 32'd0);
        chk("arst_read_en", 32'(bus.in_read_en), 32'd0);
        chk("arst_state", 32'(state_dbg), 32'd0);
        chk("arst_local_din", 32'(bus.local_din), 32'd0);
        void'(west_q.pop_front());
        discarded++;
        @(negedge clk);
        rst = 1'b0;
        bus.west_full = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("arst_after_valids", 32'(valids()), 32'd0);
        end

        // Random traffic with random empty/full patterns
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            bus.east_full  = ($urandom_range(0, 3) == 0);
            bus.west_full  = ($urandom_range(0, 3) == 0);
            bus.local_full = ($urandom_range(0, 3) == 0);
            hold_empty     = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 2) == 0 && src_q.size() < 8) begin
                rdx = DX_WIDTH'($urandom_range(0, 511));
                if ($urandom_range(0, 5) == 0) rdx = '0;
                rpl = PL_WIDTH'($urandom);
                if (rdx == '0) begin
                    push_pkt({rdx, rpl}, D_LOCAL, {9'h000, rpl});
                end else if (rdx[DX_WIDTH-1]) begin
                    push_pkt({rdx, rpl}, D_WEST, {rdx + 9'd1, rpl});
                end else begin
                    push_pkt({rdx, rpl}, D_EAST, {rdx - 9'd1, rpl});
                end
            end
        end

        // Drain with a bounded wait
        @(negedge clk);
        bus.east_full  = 1'b0;
        bus.west_full  = 1'b0;
        bus.local_full = 1'b0;
        hold_empty     = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            step();
            done = (src_q.size() == 0) && (east_q.size() == 0) && (west_q.size() == 0) &&
                   (local_q.size() == 0) && (state_dbg == 2'd0);
        end
        chk("drain_done", 32'(done), 32'd1);
        chk("total_pops", 32'(pop_count), 32'(push_count));
        chk("total_strobes", 32'(strobes), 32'(push_count - discarded));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
